// File: rtl/dma_steal_ctrl.sv
// Cycle-stealing DMA controller: moves device beats into memory, dropping BR after
// every STEAL_BEATS beats and pulsing interrupt once the whole command has been written.
module dma_steal_ctrl #(
   parameter int WORD_SIZE   = 16,
   parameter int BURST_WORDS = 4,
   parameter int BEAT_CYCLES = 4,
   parameter int STEAL_BEATS = 1,
   parameter int GAP_CYCLES  = 2,
   parameter int OFFSET_W    = 2
) (
   input  logic                             CLK,
   input  logic                             reset,
   input  logic                             cmd,
   input  logic [WORD_SIZE-1:0]             cmd_addr,
   input  logic [WORD_SIZE-1:0]             cmd_len,
   input  logic                             BG,
   input  logic [BURST_WORDS*WORD_SIZE-1:0] edata,
   output logic                             BR,
   output logic                             WRITE,
   output logic [WORD_SIZE-1:0]             addr,
   output logic [BURST_WORDS*WORD_SIZE-1:0] data,
   output logic [OFFSET_W-1:0]              offset,
   output logic                             interrupt,
   output logic                             busy
);
   localparam int MAX_BEATS = 2**OFFSET_W;
   localparam int GAP_N     = (GAP_CYCLES > 1) ? GAP_CYCLES : 1;
   localparam int CNT_W     = OFFSET_W + 1;
   localparam int CYC_W     = $clog2(BEAT_CYCLES + 1);
   localparam int GRP_W     = $clog2(STEAL_BEATS + 1);
   localparam int GAP_W     = $clog2(GAP_N + 1);
   localparam int LEN_W     = WORD_SIZE + 1;

   typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;

   state_t               state_q, state_d;
   logic                 br_q, br_d;
   logic                 irq_q, irq_d;
   logic [WORD_SIZE-1:0] base_q, base_d;
   logic [OFFSET_W-1:0]  offset_q, offset_d;
   logic [CNT_W-1:0]     rem_q, rem_d;
   logic [CYC_W-1:0]     cyc_q, cyc_d;
   logic [GRP_W-1:0]     grp_q, grp_d;
   logic [GAP_W-1:0]     gap_q, gap_d;
   logic [LEN_W-1:0]     beats_raw;
   logic [CNT_W-1:0]     cmd_beats;
   logic                 owner;

   // One extra bit keeps the round-up from overflowing on the largest lengths.
   assign beats_raw = (LEN_W'(cmd_len) + LEN_W'(BURST_WORDS - 1)) / LEN_W'(BURST_WORDS);
   assign cmd_beats = (beats_raw > LEN_W'(MAX_BEATS)) ? CNT_W'(MAX_BEATS) : CNT_W'(beats_raw);

   assign owner     = br_q & BG;
   assign BR        = br_q;
   assign WRITE     = owner;
   assign interrupt = irq_q;
   assign busy      = (state_q != IDLE);
   assign offset    = offset_q;
   assign addr      = owner ? base_q + WORD_SIZE'(offset_q) * WORD_SIZE'(BURST_WORDS) : 'z;
   assign data      = owner ? edata : 'z;

   always_comb begin
      state_d  = state_q;
      br_d     = br_q;
      irq_d    = 1'b0;
      base_d   = base_q;
      offset_d = offset_q;
      rem_d    = rem_q;
      cyc_d    = cyc_q;
      grp_d    = grp_q;
      gap_d    = gap_q;
      case (state_q)
         IDLE: begin
            // A command arriving alongside the completion pulse is dropped.
            if (cmd && !irq_q) begin
               base_d   = cmd_addr;
               offset_d = '0;
               rem_d    = cmd_beats;
               cyc_d    = '0;
               grp_d    = '0;
               if (cmd_beats == '0) begin
                  irq_d = 1'b1;
               end else begin
                  br_d    = 1'b1;
                  state_d = REQ;
               end
            end
         end
         REQ, XFER: begin
            if (!BG) begin
               cyc_d   = '0;
               state_d = REQ;
            end else if (cyc_q == CYC_W'(BEAT_CYCLES - 1)) begin
               cyc_d    = '0;
               offset_d = offset_q + 1'b1;
               rem_d    = rem_q - 1'b1;
               state_d  = XFER;
               if (rem_q == CNT_W'(1)) begin
                  br_d    = 1'b0;
                  irq_d   = 1'b1;
                  grp_d   = '0;
                  state_d = IDLE;
               end else if (grp_q == GRP_W'(STEAL_BEATS - 1)) begin
                  br_d    = 1'b0;
                  grp_d   = '0;
                  gap_d   = '0;
                  state_d = GAP;
               end else begin
                  grp_d = grp_q + 1'b1;
               end
            end else begin
               cyc_d   = cyc_q + 1'b1;
               state_d = XFER;
            end
         end
         GAP: begin
            if (gap_q == GAP_W'(GAP_N - 1)) begin
               br_d    = 1'b1;
               state_d = REQ;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q  <= IDLE;
         br_q     <= 1'b0;
         irq_q    <= 1'b0;
         base_q   <= '0;
         offset_q <= '0;
         rem_q    <= '0;
         cyc_q    <= '0;
         grp_q    <= '0;
         gap_q    <= '0;
      end else begin
         state_q  <= state_d;
         br_q     <= br_d;
         irq_q    <= irq_d;
         base_q   <= base_d;
         offset_q <= offset_d;
         rem_q    <= rem_d;
         cyc_q    <= cyc_d;
         grp_q    <= grp_d;
         gap_q    <= gap_d;
      end
   end

endmodule

// File: tb/tb_dma_steal_ctrl.sv
// Bench for dma_steal_ctrl: per-cycle comparison against a transfer-level model,
// directed scenarios pinned by literal expectations, then randomized traffic.
module tb_dma_steal_ctrl;
   localparam int W = 16, BW = 4, BC = 4, SB = 1, GC = 2, OW = 2, DW = BW * W;
   localparam int GAPN = (GC > 1) ? GC : 1;

   logic          CLK = 1'b0;
   logic          reset, cmd, bg_follow, bg_drv;
   logic [W-1:0]  cmd_addr, cmd_len;
   logic [DW-1:0] edata;
   wire           BG, BR, WRITE, interrupt, busy;
   wire [W-1:0]   addr;
   wire [DW-1:0]  data;
   wire [OW-1:0]  offset;
   wire           BG3, BR3, WRITE3, irq3, busy3;
   wire [W-1:0]   addr3;
   wire [DW-1:0]  data3;
   wire [OW-1:0]  offset3;

   assign BG  = bg_follow ? BR : bg_drv;
   assign BG3 = BR3;

   always #5 CLK = ~CLK;

   dma_steal_ctrl dut (
      .CLK(CLK), .reset(reset), .cmd(cmd), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .BG(BG), .edata(edata), .BR(BR), .WRITE(WRITE), .addr(addr), .data(data),
      .offset(offset), .interrupt(interrupt), .busy(busy));

   dma_steal_ctrl #(.STEAL_BEATS(3)) dut3 (
      .CLK(CLK), .reset(reset), .cmd(cmd), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .BG(BG3), .edata(edata), .BR(BR3), .WRITE(WRITE3), .addr(addr3), .data(data3),
      .offset(offset3), .interrupt(irq3), .busy(busy3));

   int n_chk = 0, n_pass = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   function automatic int beats_of(input int len);
      int b;
      b = (len + BW - 1) / BW;
      return (b > 2**OW) ? 2**OW : b;
   endfunction

   // Transfer-level model: beats written so far, progress inside the current beat,
   // beats in the current grant, and idle gap length.
   int m_st = 0, m_br = 0, m_irq = 0, m_done = 0, m_beats = 0;
   int m_cyc = 0, m_grp = 0, m_gap = 0;
   logic [W-1:0] m_base = '0;

   always @(posedge CLK) begin : ref_model
      int was_irq, g;
      g = bg_follow ? m_br : int'(bg_drv);
      if (reset) begin
         m_st = 0; m_br = 0; m_irq = 0; m_done = 0; m_cyc = 0; m_grp = 0; m_gap = 0;
      end else begin
         was_irq = m_irq;
         m_irq = 0;
         if (m_st == 0) begin
            if (cmd && was_irq == 0) begin
               m_base = cmd_addr; m_beats = beats_of(int'(cmd_len));
               m_done = 0; m_cyc = 0; m_grp = 0;
               if (m_beats == 0) m_irq = 1;
               else begin m_br = 1; m_st = 1; end
            end
         end else if (m_st == 1) begin
            if (g == 0) m_cyc = 0;
            else if (m_cyc == BC - 1) begin
               m_cyc = 0; m_done++; m_grp++;
               if (m_done == m_beats) begin m_br = 0; m_irq = 1; m_st = 0; m_grp = 0; end
               else if (m_grp == SB) begin m_br = 0; m_grp = 0; m_gap = 0; m_st = 2; end
            end else m_cyc++;
         end else begin
            m_gap++;
            if (m_gap >= GAPN) begin m_br = 1; m_st = 1; end
         end
      end
   end

   logic chk_en = 1'b1;
   always @(negedge CLK) if (chk_en) begin : cmp
      logic ew;
      logic [W-1:0] ea;
      ew = (m_br != 0) && (bg_follow ? (m_br != 0) : bg_drv);
      ea = m_base + W'(m_done * BW);
      check("BR", 64'(BR), 64'(m_br));
      check("WRITE", 64'(WRITE), 64'(ew));
      check("interrupt", 64'(interrupt), 64'(m_irq));
      check("busy", 64'(busy), 64'(m_st != 0));
      check("offset", 64'(offset), 64'(m_done % (2**OW)));
      if (ew) begin
         check("addr", 64'(addr), 64'(ea));
         check("data", 64'(data), 64'(edata));
      end
   end

   // Event counters for the directed scenarios.
   logic mon_clr = 1'b0, br3_prev = 1'b0;
   int wr_cnt, irq_cnt, br_cnt, gap_cnt, w3, i3, b3, r3;
   logic [W-1:0]  wr_addr [64];
   logic [OW-1:0] wr_off  [64];
   always @(negedge CLK) begin : mon
      if (mon_clr) begin
         wr_cnt = 0; irq_cnt = 0; br_cnt = 0; gap_cnt = 0;
         w3 = 0; i3 = 0; b3 = 0; r3 = 0; br3_prev = 1'b0;
      end else begin
         if (WRITE && wr_cnt < 64) begin
            wr_addr[wr_cnt] = addr; wr_off[wr_cnt] = offset; wr_cnt++;
         end
         if (interrupt) irq_cnt++;
         if (BR) br_cnt++;
         if (busy && !BR) gap_cnt++;
         if (WRITE3) w3++;
         if (irq3) i3++;
         if (BR3) b3++;
         if (BR3 && !br3_prev) r3++;
         br3_prev = BR3;
      end
   end

   task automatic tick;
      @(posedge CLK);
      #1;
      edata = {$urandom, $urandom};
   endtask

   task automatic clear_mon;
      mon_clr = 1'b1; tick; mon_clr = 1'b0;
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] l);
      cmd_addr = a; cmd_len = l; cmd = 1'b1; tick; cmd = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int k;
      k = 0;
      while (m_st != 0 && k < 400) begin tick; k++; end
      if (k >= 400) begin n_chk++; $display("FAIL %s: timeout waiting for idle", nm); end
      repeat (3) tick;
   endtask

   task automatic wait_wr(input int n, input string nm);
      int k;
      k = 0;
      while (wr_cnt < n && k < 200) begin tick; k++; end
      if (k >= 200) begin n_chk++; $display("FAIL %s: timeout waiting for writes", nm); end
   endtask

   initial begin
      reset = 1'b1; cmd = 1'b0; cmd_addr = '0; cmd_len = '0; edata = '0;
      bg_follow = 1'b1; bg_drv = 1'b0;
      repeat (3) tick;
      @(negedge CLK);
      check("rst_BR", 64'(BR), 64'(0));
      check("rst_WRITE", 64'(WRITE), 64'(0));
      check("rst_irq", 64'(interrupt), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_offset", 64'(offset), 64'(0));
      reset = 1'b0;
      tick;

      // Basic 3-beat command; the STEAL_BEATS=3 instance sees the same command.
      clear_mon;
      issue(16'h01F4, 16'd12);
      wait_idle("t1");
      check("t1_writes", 64'(wr_cnt), 64'(12));
      check("t1_irq", 64'(irq_cnt), 64'(1));
      check("t1_gap", 64'(gap_cnt), 64'(4));
      check("t1_addr0", 64'(wr_addr[0]), 64'(16'h01F4));
      check("t1_addr4", 64'(wr_addr[4]), 64'(16'h01F8));
      check("t1_addr11", 64'(wr_addr[11]), 64'(16'h01FC));
      check("t1_off4", 64'(wr_off[4]), 64'(1));
      check("t1_off8", 64'(wr_off[8]), 64'(2));
      check("t3_writes", 64'(w3), 64'(12));
      check("t3_br_cycles", 64'(b3), 64'(12));
      check("t3_grants", 64'(r3), 64'(1));
      check("t3_irq", 64'(i3), 64'(1));

      // Zero length completes immediately without requesting the bus.
      clear_mon;
      issue(16'h1234, 16'd0);
      @(negedge CLK);
      check("t2_irq_next", 64'(interrupt), 64'(1));
      repeat (5) tick;
      check("t2_writes", 64'(wr_cnt), 64'(0));
      check("t2_br", 64'(br_cnt), 64'(0));
      check("t2_irq", 64'(irq_cnt), 64'(1));

      // Grant revoked in cycle 2 of beat 1 for 3 cycles.
      clear_mon;
      bg_follow = 1'b0; bg_drv = 1'b1;
      issue(16'h01F4, 16'd12);
      wait_wr(6, "t4");
      bg_drv = 1'b0;
      repeat (3) tick;
      bg_drv = 1'b1;
      wait_idle("t4");
      bg_follow = 1'b1;
      begin
         int n18;
         n18 = 0;
         for (int i = 0; i < 14; i++) if (wr_addr[i] == 16'h01F8) n18++;
         check("t4_replay_01F8", 64'(n18), 64'(6));
      end
      check("t4_writes", 64'(wr_cnt), 64'(14));
      check("t4_irq", 64'(irq_cnt), 64'(1));

      // Reset mid-transfer abandons the command.
      clear_mon;
      issue(16'h0200, 16'd12);
      wait_wr(5, "t5");
      reset = 1'b1;
      tick;
      @(negedge CLK);
      check("t5_BR", 64'(BR), 64'(0));
      check("t5_busy", 64'(busy), 64'(0));
      check("t5_irq", 64'(interrupt), 64'(0));
      reset = 1'b0;
      repeat (10) tick;
      check("t5_no_irq", 64'(irq_cnt), 64'(0));
      clear_mon;
      issue(16'h0300, 16'd4);
      wait_idle("t5b");
      check("t5_writes", 64'(wr_cnt), 64'(4));
      check("t5_off0", 64'(wr_off[0]), 64'(0));
      check("t5_addr0", 64'(wr_addr[0]), 64'(16'h0300));

      // Address wrap; commands while busy and during the interrupt cycle are dropped.
      clear_mon;
      issue(16'hFFFC, 16'd8);
      wait_wr(2, "t6");
      issue(16'h1111, 16'd4);
      begin
         int k;
         k = 0;
         while (m_irq == 0 && k < 200) begin tick; k++; end
         if (k >= 200) begin n_chk++; $display("FAIL t6: timeout waiting for interrupt"); end
      end
      issue(16'h2222, 16'd4);
      repeat (12) tick;
      check("t6_writes", 64'(wr_cnt), 64'(8));
      check("t6_irq", 64'(irq_cnt), 64'(1));
      check("t6_addr0", 64'(wr_addr[0]), 64'(16'hFFFC));
      check("t6_addr4", 64'(wr_addr[4]), 64'(16'h0000));

      // Randomized traffic: arbiter behaviour, lengths, addresses, stray grants, resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) bg_follow = 1'($urandom_range(0, 1));
         bg_drv = ($urandom_range(0, 3) != 0);
         cmd = ($urandom_range(0, 7) == 0);
         cmd_addr = 16'($urandom);
         case ($urandom_range(0, 3))
            0: cmd_len = 16'd0;
            1: cmd_len = 16'($urandom_range(1, 16));
            2: cmd_len = 16'($urandom_range(17, 40));
            default: cmd_len = 16'($urandom);
         endcase
         reset = ($urandom_range(0, 299) == 0);
         tick;
      end
      cmd = 1'b0; reset = 1'b0;
      repeat (2) tick;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
